// File: rtl/led_fader.sv
// PWM LED driver: ramps duty linearly toward the requested on/off level for a
// fade-in / fade-out "breathing" effect instead of hard switching the pin.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// OFF       | settled dark, duty=0, pin held low
// RAMP_UP   | duty climbs one count per prescaler step toward MAX
// ON        | settled lit, duty=MAX, pin held high
// RAMP_DOWN | duty falls one count per prescaler step toward 0
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 390625,
  parameter int DIV_BITS = 19
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                target,
  output logic                led,
  output logic [PWM_BITS-1:0] level,
  output logic                fading
);

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_e;

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(STEP_DIV - 1);

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q,  duty_d;
  logic [PWM_BITS-1:0] pwm_q,   pwm_d;
  logic [DIV_BITS-1:0] div_q,   div_d;
  logic                led_q,   led_d;
  logic                ramping;
  logic                step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      duty_q  <= '0;
      pwm_q   <= '0;
      div_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pwm_q   <= pwm_d;
      div_q   <= div_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    pwm_d   = pwm_q + 1'b1;
    div_d   = div_q;
    led_d   = 1'b0;
    ramping = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    step    = ramping && (div_q == DIV_LAST);

    // A reversal wins over a coincident step: direction flips, duty holds.
    unique case (state_q)
      OFF: begin
        if (target) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (!target) begin
          state_d = RAMP_DOWN;
        end else if (step) begin
          if (duty_q == DUTY_MAX) state_d = ON;
          else                    duty_d  = duty_q + 1'b1;
        end
      end
      ON: begin
        if (!target) begin
          state_d = RAMP_DOWN;
          duty_d  = DUTY_MAX;
        end
      end
      RAMP_DOWN: begin
        if (target) begin
          state_d = RAMP_UP;
        end else if (step) begin
          if (duty_q == '0) state_d = OFF;
          else              duty_d  = duty_q - 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    if (state_d != state_q) div_d = '0;
    else if (step)          div_d = '0;
    else if (ramping)       div_d = div_q + 1'b1;

    unique case (state_q)
      ON:      led_d = 1'b1;
      OFF:     led_d = 1'b0;
      default: led_d = (duty_q > pwm_q);
    endcase
  end

  assign led    = led_q;
  assign level  = duty_q;
  assign fading = ramping;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: directed fade scenarios plus randomized
// target/reset traffic compared cycle by cycle against a behavioural model.
module tb_led_fader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, tgt_a, led_a, fad_a;
  logic [3:0] lvl_a;
  logic       rst_b, tgt_b, led_b, fad_b;
  logic [3:0] lvl_b;
  logic       rst_c, tgt_c, led_c, fad_c;
  logic [3:0] lvl_c;

  led_fader #(.PWM_BITS(4), .STEP_DIV(2), .DIV_BITS(2)) dut_a (
    .clk(clk), .rst(rst_a), .target(tgt_a), .led(led_a), .level(lvl_a), .fading(fad_a));
  led_fader #(.PWM_BITS(4), .STEP_DIV(1000), .DIV_BITS(10)) dut_b (
    .clk(clk), .rst(rst_b), .target(tgt_b), .led(led_b), .level(lvl_b), .fading(fad_b));
  led_fader #(.PWM_BITS(4), .STEP_DIV(1), .DIV_BITS(1)) dut_c (
    .clk(clk), .rst(rst_c), .target(tgt_c), .led(led_c), .level(lvl_c), .fading(fad_c));

  int checks = 0;
  int failures = 0;

  // Behavioural model of dut_a: mode 0=off 1=up 2=on 3=down, plain integers.
  int m_mode = 0, m_duty = 0, m_div = 0, m_pwm = 0, m_led = 0;

  task automatic model_step();
    int  nx_mode, nx_duty;
    bit  moving, stepping;
    if (rst_a) begin
      m_mode = 0; m_duty = 0; m_div = 0; m_pwm = 0; m_led = 0;
      return;
    end
    moving   = (m_mode == 1) || (m_mode == 3);
    stepping = moving && (m_div == 2 - 1);
    if (m_mode == 2)      m_led = 1;
    else if (m_mode == 0) m_led = 0;
    else                  m_led = (m_duty > m_pwm) ? 1 : 0;
    m_pwm   = (m_pwm + 1) % 16;
    nx_mode = m_mode;
    nx_duty = m_duty;
    case (m_mode)
      0: if (tgt_a) nx_mode = 1;
      1: if (!tgt_a) nx_mode = 3;
         else if (stepping) begin
           if (m_duty == 15) nx_mode = 2; else nx_duty = m_duty + 1;
         end
      2: if (!tgt_a) begin nx_mode = 3; nx_duty = 15; end
      default: if (tgt_a) nx_mode = 1;
         else if (stepping) begin
           if (m_duty == 0) nx_mode = 0; else nx_duty = m_duty - 1;
         end
    endcase
    if (nx_mode != m_mode) m_div = 0;
    else if (moving)       m_div = stepping ? 0 : m_div + 1;
    m_mode = nx_mode;
    m_duty = nx_duty;
  endtask

  // Every posedge of the run passes through here, keeping the model in lockstep.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_a = 1'b1; tgt_a = 1'b1;
    repeat (3) tick();
    checks++; if (led_a !== 1'b0) begin failures++; $display("FAIL reset_led got=%b exp=0", led_a); end
    checks++; if (lvl_a !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", lvl_a); end
    checks++; if (fad_a !== 1'b0) begin failures++; $display("FAIL reset_fading got=%b exp=0", fad_a); end
    rst_a = 1'b0;
    tick();
    checks++; if (fad_a !== 1'b1) begin failures++; $display("FAIL release_fading got=%b exp=1", fad_a); end
  endtask

  task automatic test_fade_in();
    logic [3:0] exp_lvl;
    logic       exp_fad;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_lvl = (k / 2 > 15) ? 4'd15 : 4'(k / 2);
      exp_fad = (k < 32);
      checks++; if (lvl_a !== exp_lvl) begin failures++; $display("FAIL fade_in_level k=%0d got=%0d exp=%0d", k, lvl_a, exp_lvl); end
      checks++; if (fad_a !== exp_fad) begin failures++; $display("FAIL fade_in_fading k=%0d got=%b exp=%b", k, fad_a, exp_fad); end
    end
    tick();
    for (int k = 0; k < 64; k++) begin
      tick();
      checks++; if ({led_a, fad_a} !== 2'b10) begin failures++; $display("FAIL on_steady cyc=%0d led=%b fading=%b exp led=1 fading=0", k, led_a, fad_a); end
    end
  endtask

  task automatic test_fade_out();
    logic [3:0] exp_lvl;
    logic       exp_fad;
    tgt_a = 1'b0;
    tick();
    checks++; if ({lvl_a, fad_a} !== {4'd15, 1'b1}) begin failures++; $display("FAIL fade_out_entry level=%0d fading=%b exp 15/1", lvl_a, fad_a); end
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_lvl = (k / 2 > 15) ? 4'd0 : 4'(15 - k / 2);
      exp_fad = (k < 32);
      checks++; if (lvl_a !== exp_lvl) begin failures++; $display("FAIL fade_out_level k=%0d got=%0d exp=%0d", k, lvl_a, exp_lvl); end
      checks++; if (fad_a !== exp_fad) begin failures++; $display("FAIL fade_out_fading k=%0d got=%b exp=%b", k, fad_a, exp_fad); end
    end
    tick();
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++; if ({led_a, fad_a, lvl_a} !== 6'd0) begin failures++; $display("FAIL off_steady cyc=%0d led=%b fading=%b level=%0d exp all 0", k, led_a, fad_a, lvl_a); end
    end
  endtask

  task automatic test_reversal();
    tgt_a = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) tick();
    checks++; if (lvl_a !== 4'd7) begin failures++; $display("FAIL rev_pre_level got=%0d exp=7", lvl_a); end
    tgt_a = 1'b0;
    tick();
    checks++; if ({lvl_a, fad_a} !== {4'd7, 1'b1}) begin failures++; $display("FAIL rev_hold level=%0d fading=%b exp 7/1", lvl_a, fad_a); end
    tick();
    checks++; if (lvl_a !== 4'd7) begin failures++; $display("FAIL rev_wait_level got=%0d exp=7", lvl_a); end
    tick();
    checks++; if (lvl_a !== 4'd6) begin failures++; $display("FAIL rev_down_level got=%0d exp=6", lvl_a); end
    tgt_a = 1'b1;
    tick();
    checks++; if ({lvl_a, fad_a} !== {4'd6, 1'b1}) begin failures++; $display("FAIL rev_up_entry level=%0d fading=%b exp 6/1", lvl_a, fad_a); end
    tick();
    checks++; if (lvl_a !== 4'd6) begin failures++; $display("FAIL rev_up_wait got=%0d exp=6", lvl_a); end
    tick();
    checks++; if (lvl_a !== 4'd7) begin failures++; $display("FAIL rev_up_climb got=%0d exp=7", lvl_a); end
  endtask

  task automatic test_reset_mid_ramp();
    repeat (4) tick();
    checks++; if (lvl_a !== 4'd9) begin failures++; $display("FAIL mid_pre_level got=%0d exp=9", lvl_a); end
    tgt_a = 1'b0;
    tick();
    checks++; if ({lvl_a, fad_a} !== {4'd9, 1'b1}) begin failures++; $display("FAIL mid_down level=%0d fading=%b exp 9/1", lvl_a, fad_a); end
    rst_a = 1'b1; tgt_a = 1'b1;
    tick();
    checks++; if ({led_a, fad_a, lvl_a} !== 6'd0) begin failures++; $display("FAIL mid_reset led=%b fading=%b level=%0d exp all 0", led_a, fad_a, lvl_a); end
    rst_a = 1'b0;
    tick();
    checks++; if ({lvl_a, fad_a} !== {4'd0, 1'b1}) begin failures++; $display("FAIL mid_release level=%0d fading=%b exp 0/1", lvl_a, fad_a); end
  endtask

  task automatic test_pwm_duty();
    int  highs;
    logic exp_led;
    tick();
    rst_b = 1'b0; tgt_b = 1'b1;
    for (int n = 1; n <= 5001; n++) tick();
    checks++; if ({lvl_b, fad_b} !== {4'd5, 1'b1}) begin failures++; $display("FAIL pwm_level level=%0d fading=%b exp 5/1", lvl_b, fad_b); end
    highs = 0;
    for (int n = 5002; n < 5002 + 16 * 60; n++) begin
      tick();
      exp_led = (((n - 1) % 16) < 5);
      if (led_b === 1'b1) highs++;
      checks++; if (led_b !== exp_led) begin failures++; $display("FAIL pwm_led n=%0d got=%b exp=%b", n, led_b, exp_led); end
    end
    checks++; if (highs != 300) begin failures++; $display("FAIL pwm_high_count got=%0d exp=300", highs); end
  endtask

  task automatic test_step_div1();
    logic [3:0] exp_lvl;
    tick();
    rst_c = 1'b0; tgt_c = 1'b1;
    tick();
    checks++; if ({lvl_c, fad_c} !== {4'd0, 1'b1}) begin failures++; $display("FAIL div1_entry level=%0d fading=%b exp 0/1", lvl_c, fad_c); end
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_lvl = (k > 15) ? 4'd15 : 4'(k);
      checks++; if (lvl_c !== exp_lvl) begin failures++; $display("FAIL div1_level k=%0d got=%0d exp=%0d", k, lvl_c, exp_lvl); end
      checks++; if (fad_c !== (k < 16)) begin failures++; $display("FAIL div1_fading k=%0d got=%b exp=%b", k, fad_c, (k < 16)); end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        tgt_a = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 80);
      end else begin
        hold--;
      end
      rst_a = ($urandom_range(0, 199) == 0);
      tick();
      checks++; if (lvl_a !== 4'(m_duty)) begin failures++; $display("FAIL rand_level i=%0d got=%0d exp=%0d", i, lvl_a, m_duty); end
      checks++; if (fad_a !== ((m_mode == 1) || (m_mode == 3))) begin failures++; $display("FAIL rand_fading i=%0d got=%b exp mode=%0d", i, fad_a, m_mode); end
      checks++; if (led_a !== 1'(m_led)) begin failures++; $display("FAIL rand_led i=%0d got=%b exp=%0d", i, led_a, m_led); end
    end
    rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; tgt_a = 1'b0;
    rst_b = 1'b1; tgt_b = 1'b0;
    rst_c = 1'b1; tgt_c = 1'b0;
    test_reset();
    test_fade_in();
    test_fade_out();
    test_reversal();
    test_reset_mid_ramp();
    test_pwm_duty();
    test_step_div1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
